// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory stage between execute and writeback. Passes ALU
//               results through, runs load/store handshakes on the data bus,
//               extends load data and stalls upstream while a bus
//               transaction is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            E_valid_i,
  input  logic [XLEN-1:0] E_valE_i,
  input  logic [XLEN-1:0] E_rs2_data_i,
  input  logic            E_op_load_i,
  input  logic            E_op_store_i,
  input  logic [2:0]      E_funct3_i,
  input  logic [4:0]      E_rd_i,
  input  logic            E_wb_en_i,
  output logic            M_stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            M_valid_o,
  output logic [XLEN-1:0] M_valM_o,
  output logic [4:0]      M_rd_o,
  output logic            M_wb_en_o,
  output logic            M_misalign_o,
  output logic            M_bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] tmo_cnt;

  // transaction context latched when a memory op is accepted
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            wb_en_q;

  // decode of the incoming instruction
  logic            is_mem;
  logic            is_byte;
  logic            is_half;
  logic            misalign;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic            tmo_hit;

  // load data path
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] ld_ext;

  assign M_stall_o    = (state != IDLE);
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;
  // counter keeps running on the gnt cycle, so compare with >= to stay safe
  assign tmo_hit      = (tmo_cnt >= TMO_LAST);

  // size decode, alignment check and store lane formatting
  always_comb begin
    is_mem   = E_op_load_i | E_op_store_i;
    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    is_byte  = (E_funct3_i[1:0] == 2'b00);
    is_half  = (E_funct3_i[1:0] == 2'b01);
    misalign = 1'b0;
    st_wdata = E_rs2_data_i;
    st_wstrb = 4'b1111;
    if (is_byte) begin
      st_wdata = {(XLEN/8){E_rs2_data_i[7:0]}};
      st_wstrb = 4'b0001 << E_valE_i[1:0];
    end else if (is_half) begin
      misalign = E_valE_i[0];
      st_wdata = {(XLEN/16){E_rs2_data_i[15:0]}};
      st_wstrb = 4'b0011 << E_valE_i[1:0];
    end else begin
      misalign = (E_valE_i[1:0] != 2'b00);
    end
    misalign = misalign & is_mem;
  end

  // lane select and sign/zero extension of returned load data
  always_comb begin
    rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // stage FSM with registered writeback outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      M_valid_o    <= 1'b0;
      M_valM_o     <= '0;
      M_rd_o       <= '0;
      M_wb_en_o    <= 1'b0;
      M_misalign_o <= 1'b0;
      M_bus_err_o  <= 1'b0;
    end else begin
      M_valid_o    <= 1'b0;
      M_wb_en_o    <= 1'b0;
      M_misalign_o <= 1'b0;
      M_bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (E_valid_i) begin
            if (!is_mem) begin
              M_valid_o <= 1'b1;
              M_valM_o  <= E_valE_i;
              M_rd_o    <= E_rd_i;
              M_wb_en_o <= E_wb_en_i;
            end else if (misalign) begin
              M_valid_o    <= 1'b1;
              M_valM_o     <= E_valE_i;
              M_rd_o       <= E_rd_i;
              M_misalign_o <= 1'b1;
            end else begin
              // load wins if both op flags are set
              addr_q   <= E_valE_i;
              we_q     <= E_op_store_i & ~E_op_load_i;
              wdata_q  <= st_wdata;
              wstrb_q  <= E_op_load_i ? 4'b0000 : st_wstrb;
              funct3_q <= E_funct3_i;
              rd_q     <= E_rd_i;
              wb_en_q  <= E_wb_en_i;
              tmo_cnt  <= '0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (we_q) begin
              M_valid_o <= 1'b1;
              M_valM_o  <= addr_q;
              M_rd_o    <= rd_q;
              state     <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_hit) begin
            M_valid_o   <= 1'b1;
            M_valM_o    <= '0;
            M_rd_o      <= rd_q;
            M_bus_err_o <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            M_valid_o <= 1'b1;
            M_valM_o  <= ld_ext;
            M_rd_o    <= rd_q;
            M_wb_en_o <= wb_en_q;
            state     <= IDLE;
          end else if (tmo_hit) begin
            M_valid_o   <= 1'b1;
            M_valM_o    <= '0;
            M_rd_o      <= rd_q;
            M_bus_err_o <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Scoreboard bench for mem_access with a configurable bus
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            e_valid = 1'b0;
  logic [31:0]     e_valE = '0;
  logic [31:0]     e_rs2 = '0;
  logic            e_ld = 1'b0;
  logic            e_st = 1'b0;
  logic [2:0]      e_f3 = '0;
  logic [4:0]      e_rd = '0;
  logic            e_wb = 1'b0;
  logic            m_stall;
  logic            dmem_req;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_gnt = 1'b0;
  logic            dmem_rvalid = 1'b0;
  logic [31:0]     dmem_rdata = '0;
  logic            m_valid;
  logic [31:0]     m_valM;
  logic [4:0]      m_rd;
  logic            m_wb_en;
  logic            m_misalign;
  logic            m_bus_err;

  mem_access #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .E_valid_i(e_valid), .E_valE_i(e_valE), .E_rs2_data_i(e_rs2),
    .E_op_load_i(e_ld), .E_op_store_i(e_st), .E_funct3_i(e_f3),
    .E_rd_i(e_rd), .E_wb_en_i(e_wb),
    .M_stall_o(m_stall),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_wstrb_o(dmem_wstrb),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .M_valid_o(m_valid), .M_valM_o(m_valM), .M_rd_o(m_rd), .M_wb_en_o(m_wb_en),
    .M_misalign_o(m_misalign), .M_bus_err_o(m_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    bit          chk_val;
    logic [4:0]  rd;
    bit          wb;
    bit          mis;
    bit          berr;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int req_cnt   = 0;

  // responder configuration
  bit          resp_en   = 1'b1;
  int          gnt_wait  = 0;
  int          rv_delay  = 1;
  bit          gnt_never = 1'b0;
  int          req_cycles = 0;
  bit          pend_rv = 1'b0;
  int          rv_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // bus responder: gnt after gnt_wait request cycles, rvalid rv_delay cycles later
  always @(negedge clk) begin
    if (resp_en) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (dmem_req) begin
        if (!gnt_never && req_cycles == gnt_wait) begin
          bus_t b;
          dmem_gnt   = 1'b1;
          req_cycles = 0;
          if (bus_q.size() == 0) check("bus_unexpected", 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            check("bus_addr", dmem_addr, b.addr);
            check("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
            check("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, b.wstrb});
            if (b.we) check("bus_wdata", dmem_wdata, b.wdata);
          end
          if (!dmem_we) begin
            pend_rv = 1'b1;
            rv_cnt  = 0;
          end
        end else begin
          req_cycles++;
        end
      end else if (pend_rv) begin
        req_cycles = 0;
        rv_cnt++;
        if (rv_cnt == rv_delay) begin
          dmem_rvalid = 1'b1;
          pend_rv     = 1'b0;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // writeback monitor: every result pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (dmem_req) req_cnt++;
    if (m_stall) stall_cnt++;
    if (rst_n && m_valid) begin
      if (res_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        res_t e;
        e = res_q.pop_front();
        check("m_rd", {27'd0, m_rd}, {27'd0, e.rd});
        check("m_wb_en", {31'd0, m_wb_en}, {31'd0, e.wb});
        check("m_misalign", {31'd0, m_misalign}, {31'd0, e.mis});
        check("m_bus_err", {31'd0, m_bus_err}, {31'd0, e.berr});
        if (e.chk_val) check("m_valM", m_valM, e.val);
      end
    end
  end

  // drive one instruction in the first IDLE cycle and record its expectations
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input bit wb, input logic [31:0] ld_val);
    int n = 0;
    res_t r;
    bus_t b;
    bit mem, mis;
    @(negedge clk);
    while (m_stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("issue_timeout", 32'd1, 32'd0);
    mem = ld | st;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a[1:0] != 2'b00);
    endcase
    mis = mis & mem;
    r.rd = rd; r.val = a; r.chk_val = 1'b1; r.wb = 1'b0; r.mis = 1'b0; r.berr = 1'b0;
    if (!mem) r.wb = wb;
    else if (mis) begin
      r.mis = 1'b1; r.chk_val = 1'b0;
    end else begin
      b.addr = a; b.we = st & ~ld; b.wdata = 32'd0; b.wstrb = 4'b0000;
      if (b.we) begin
        case (f3[1:0])
          2'b00:   begin b.wdata = {4{rs2[7:0]}};  b.wstrb = 4'b0001 << a[1:0]; end
          2'b01:   begin b.wdata = {2{rs2[15:0]}}; b.wstrb = a[1] ? 4'b1100 : 4'b0011; end
          default: begin b.wdata = rs2;            b.wstrb = 4'b1111; end
        endcase
      end
      bus_q.push_back(b);
      if (ld) begin
        if (gnt_never) begin
          r.berr = 1'b1; r.chk_val = 1'b0;
        end else begin
          r.val = ld_val; r.wb = wb;
        end
      end
    end
    res_q.push_back(r);
    e_valid = 1'b1; e_ld = ld; e_st = st; e_f3 = f3;
    e_valE = a; e_rs2 = rs2; e_rd = rd; e_wb = wb;
    @(negedge clk);
    e_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (res_q.size() == 0 && !m_stall) return;
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [2:0]  ld_f3 [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b000, 3'b110};
  logic [31:0] ld_a  [9] = '{32'h103, 32'h102, 32'h202, 32'h200, 32'h204, 32'h208, 32'h10C, 32'h100, 32'h110};
  logic [31:0] ld_rd [9] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_F234, 32'h7FFF_8000,
                             32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F, 32'h1234_5678};
  logic [31:0] ld_ex [9] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_F234, 32'hFFFF_8000,
                             32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F, 32'h1234_5678};
  logic [2:0]  st_f3 [5] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
  logic [31:0] st_a  [5] = '{32'h202, 32'h101, 32'h104, 32'h103, 32'h200};
  logic [31:0] st_d  [5] = '{32'h0000_ABCD, 32'h1234_565A, 32'h89AB_CDEF, 32'h0000_00C3, 32'h0000_7E11};
  logic [2:0]  mi_f3 [5] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b101};
  logic [31:0] mi_a  [5] = '{32'h101, 32'h203, 32'h201, 32'h10A, 32'h105};
  bit          mi_st [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int s0, r0;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, m_stall}, 32'd0);
    check("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("rst_flags", {29'd0, m_wb_en, m_misalign, m_bus_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ALU pass-through, latency 1
    r0 = req_cnt;
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0);
    check("alu_latency", {31'd0, m_valid}, 32'd1);
    drain();
    check("alu_no_req", req_cnt - r0, 32'd0);

    // idle cycles produce no results (monitor flags any pulse)
    repeat (3) @(negedge clk);
    check("idle_no_valid", {31'd0, m_valid}, 32'd0);

    // LB with gnt after 2 cycles and rvalid 1 cycle later: 4 stall cycles
    gnt_wait = 2; rv_delay = 1; dmem_rdata = ld_rd[0];
    s0 = stall_cnt;
    issue(1'b1, 1'b0, ld_f3[0], ld_a[0], 32'h0, 5'd7, 1'b1, ld_ex[0]);
    drain();
    check("lb_stall_cycles", stall_cnt - s0, 32'd4);

    // load lane/extension table with varied bus timing
    for (int i = 1; i < 9; i++) begin
      gnt_wait = i % 3; rv_delay = 1 + (i % 2); dmem_rdata = ld_rd[i];
      issue(1'b1, 1'b0, ld_f3[i], ld_a[i], 32'h0, 5'(i + 8), 1'b1, ld_ex[i]);
      drain();
    end

    // stores
    for (int i = 0; i < 5; i++) begin
      gnt_wait = i % 2;
      issue(1'b0, 1'b1, st_f3[i], st_a[i], st_d[i], 5'(i + 20), 1'b1, 32'h0);
      drain();
    end

    // misaligned accesses never reach the bus
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(~mi_st[i], mi_st[i], mi_f3[i], mi_a[i], 32'hFFFF_FFFF, 5'(i + 1), 1'b1, 32'h0);
      check("mis_latency", {31'd0, m_valid}, 32'd1);
    end
    drain();
    check("mis_no_req", req_cnt - r0, 32'd0);

    // load and store both set: load wins
    gnt_wait = 0; rv_delay = 1; dmem_rdata = 32'h1122_3344;
    issue(1'b1, 1'b1, 3'b010, 32'h120, 32'h5555_5555, 5'd3, 1'b1, 32'h1122_3344);
    drain();

    // back-to-back: ALU held behind a load is taken in the first IDLE cycle
    gnt_wait = 1; rv_delay = 2; dmem_rdata = 32'hA5A5_0000;
    s0 = stall_cnt;
    issue(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 5'd12, 1'b1, 32'h0000_A5A5);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_BEEF, 32'h0, 5'd13, 1'b1, 32'h0);
    check("b2b_alu_latency", {31'd0, m_valid}, 32'd1);
    drain();
    check("b2b_stall_cycles", stall_cnt - s0, 32'd4);

    // LHU with no grant: bus error after TIMEOUT cycles, FSM back in IDLE
    gnt_never = 1'b1;
    s0 = stall_cnt;
    issue(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0);
    drain();
    check("tmo_stall_cycles", stall_cnt - s0, TIMEOUT);
    check("tmo_idle", {31'd0, m_stall}, 32'd0);
    gnt_never = 1'b0;
    bus_q.delete();

    // reset during WAIT abandons the transaction
    gnt_wait = 0; rv_delay = 1000;
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b1, 32'h0);
    @(negedge clk);
    check("pre_rst_stall", {31'd0, m_stall}, 32'd1);
    resp_en = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    check("rst_wait_stall", {31'd0, m_stall}, 32'd0);
    check("rst_wait_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    res_q.delete(); bus_q.delete(); pend_rv = 1'b0; req_cycles = 0;
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rvalid_ignored", {30'd0, m_valid, m_stall}, 32'd0);
    end
    resp_en = 1'b1; rv_delay = 1;

    // recovery after reset
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd31, 1'b0, 32'h0);
    drain();

    repeat (2) @(negedge clk);
    check("queues_empty", res_q.size() + bus_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
